// File: rtl/sched_pkg.sv
// Shared types and constants for the issue scheduler.
// Entry status flags, default tag width, zero-register tag.
package sched_pkg;

  localparam int SCHED_TAG_W = 6;

  localparam logic [SCHED_TAG_W-1:0] ZERO_TAG = '0;

  typedef struct packed {
    logic valid;
    logic src1_rdy;
    logic src2_rdy;
  } entry_st_t;

endpackage

// File: rtl/sched_age_matrix.sv
// Age matrix: r_age[i][j]=1 means entry j is older than entry i.
// Grants the oldest requesting entry as a one-hot vector.
module sched_age_matrix
  import sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [DEPTH-1:0] i_alloc_oh,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_gnt
);

  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  // New entry is younger than every live one; freed columns drop out.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i_alloc_oh[i])
            r_age[i][j] <= i_valid[j] & ~i_free[j];
          else
            r_age[i][j] <= r_age[i][j] & ~i_free[j];
        end
      end
    end
  end

  // An entry wins when no older entry is also requesting.
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < DEPTH; i++)
      o_gnt[i] = i_req[i] & ~|(r_age[i] & i_req);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue queue: wakeup, oldest-ready select, dequeue.
// ISSUE_SCHED_WAKE_BYPASS_EN: same-cycle wake counts toward eligibility.
module issue_scheduler
  import sched_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = SCHED_TAG_W,
  parameter int PAYLOAD_W = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [TAG_W-1:0]           alloc_src1_tag,
  input  logic                       alloc_src1_rdy,
  input  logic [TAG_W-1:0]           alloc_src2_tag,
  input  logic                       alloc_src2_rdy,
  input  logic [PAYLOAD_W-1:0]       alloc_payload,
  input  logic                       wake_valid,
  input  logic [TAG_W-1:0]           wake_tag,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       issue_valid,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  output logic [TAG_W-1:0]           issue_src1_tag,
  output logic [TAG_W-1:0]           issue_src2_tag,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [TAG_W-1:0] ZTAG = TAG_W'(ZERO_TAG);

  entry_st_t            r_st   [DEPTH];
  logic [TAG_W-1:0]     r_tag1 [DEPTH];
  logic [TAG_W-1:0]     r_tag2 [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay  [DEPTH];
  logic [OW-1:0]        r_occ;

  logic [DEPTH-1:0] w_valid, w_wake1, w_wake2;
  logic [DEPTH-1:0] w_elig, w_gnt, w_deq_oh;
  logic [DEPTH-1:0] w_free_oh, w_alloc_oh, w_age_free;
  logic             w_alloc_fire, w_a1, w_a2;

  assign alloc_ready  = (r_occ != FULL);
  assign w_alloc_fire = alloc_valid && alloc_ready && !flush;
  assign w_a1 = alloc_src1_rdy || (alloc_src1_tag == ZTAG) ||
                (wake_valid && wake_tag == alloc_src1_tag);
  assign w_a2 = alloc_src2_rdy || (alloc_src2_tag == ZTAG) ||
                (wake_valid && wake_tag == alloc_src2_tag);

  // Per-entry wake matches and eligibility.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_st[i].valid;
      w_wake1[i] = wake_valid && (wake_tag == r_tag1[i]);
      w_wake2[i] = wake_valid && (wake_tag == r_tag2[i]);
`ifdef ISSUE_SCHED_WAKE_BYPASS_EN
      w_elig[i]  = r_st[i].valid &&
                   (r_st[i].src1_rdy || w_wake1[i]) &&
                   (r_st[i].src2_rdy || w_wake2[i]);
`else
      w_elig[i]  = r_st[i].valid &&
                   r_st[i].src1_rdy && r_st[i].src2_rdy;
`endif
    end
  end

  // Lowest-index free slot.
  always_comb begin
    w_free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_st[i].valid) begin
        w_free_oh    = '0;
        w_free_oh[i] = 1'b1;
      end
    end
  end

  assign w_alloc_oh = w_alloc_fire ? w_free_oh : '0;
  assign issue_valid = (|w_elig) && !flush && !rst;
  assign w_deq_oh   = (issue_valid && !stall) ? w_gnt : '0;
  assign w_age_free = flush ? '1 : w_deq_oh;

  sched_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .i_rst      (rst),
    .i_alloc_oh (w_alloc_oh),
    .i_valid    (w_valid),
    .i_free     (w_age_free),
    .i_req      (w_elig),
    .o_gnt      (w_gnt)
  );

  // Entry status: flush/reset clear, alloc, dequeue, wakeup.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) r_st[i] <= '0;
      r_occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_oh[i]) begin
          r_st[i] <= '{valid: 1'b1, src1_rdy: w_a1, src2_rdy: w_a2};
        end else if (w_deq_oh[i]) begin
          r_st[i] <= '0;
        end else if (r_st[i].valid) begin
          r_st[i].src1_rdy <= r_st[i].src1_rdy | w_wake1[i];
          r_st[i].src2_rdy <= r_st[i].src2_rdy | w_wake2[i];
        end
      end
      r_occ <= r_occ + OW'(w_alloc_fire) - OW'(|w_deq_oh);
    end
  end

  // Tag and payload storage, written only on allocation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc_oh[i]) begin
        r_tag1[i] <= alloc_src1_tag;
        r_tag2[i] <= alloc_src2_tag;
        r_pay[i]  <= alloc_payload;
      end
    end
  end

  // One-hot read mux of the granted entry, zero when idle.
  always_comb begin
    issue_payload  = '0;
    issue_src1_tag = '0;
    issue_src2_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_valid && w_gnt[i]) begin
        issue_payload  = issue_payload  | r_pay[i];
        issue_src1_tag = issue_src1_tag | r_tag1[i];
        issue_src2_tag = issue_src2_tag | r_tag2[i];
      end
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler.
// Expected issue payloads are queued at stimulus time.
module tb_issue_scheduler;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PW    = 96;
  localparam int OW    = 4;

  logic            clk;
  logic            rst;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [TAG_W-1:0] alloc_src1_tag;
  logic            alloc_src1_rdy;
  logic [TAG_W-1:0] alloc_src2_tag;
  logic            alloc_src2_rdy;
  logic [PW-1:0]   alloc_payload;
  logic            wake_valid;
  logic [TAG_W-1:0] wake_tag;
  logic            stall;
  logic            flush;
  logic            issue_valid;
  logic [PW-1:0]   issue_payload;
  logic [TAG_W-1:0] issue_src1_tag;
  logic [TAG_W-1:0] issue_src2_tag;
  logic [OW-1:0]   occupancy;

  int n_tests;
  int n_fail;
  int n_issued;
  logic [PW-1:0] sb_q[$];

  issue_scheduler #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_src1_tag (alloc_src1_tag),
    .alloc_src1_rdy (alloc_src1_rdy),
    .alloc_src2_tag (alloc_src2_tag),
    .alloc_src2_rdy (alloc_src2_rdy),
    .alloc_payload  (alloc_payload),
    .wake_valid     (wake_valid),
    .wake_tag       (wake_tag),
    .stall          (stall),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_payload  (issue_payload),
    .issue_src1_tag (issue_src1_tag),
    .issue_src2_tag (issue_src2_tag),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkp(input int k);
    return {32'hA5A50000 + 32'(k), 32'(k * 3), 32'hC0DE0000 | 32'(k)};
  endfunction

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_src1_tag = '0;
    alloc_src1_rdy = 1'b0;
    alloc_src2_tag = '0;
    alloc_src2_rdy = 1'b0;
    alloc_payload  = '0;
    wake_valid     = 1'b0;
    wake_tag       = '0;
    stall          = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic drv_alloc(input int t1, input logic r1,
                           input int t2, input logic r2,
                           input logic [PW-1:0] p);
    alloc_valid    = 1'b1;
    alloc_src1_tag = TAG_W'(t1);
    alloc_src1_rdy = r1;
    alloc_src2_tag = TAG_W'(t2);
    alloc_src2_rdy = r2;
    alloc_payload  = p;
  endtask

  // Sample outputs mid-cycle, retire issues against the scoreboard.
  task automatic tick();
    logic [PW-1:0] exp;
    @(negedge clk);
    if (!rst && issue_valid && !stall) begin
      n_issued++;
      if (sb_q.size() == 0) begin
        chk("unexpected_issue", 128'(issue_valid), 128'(0));
      end else begin
        exp = sb_q.pop_front();
        chk("issue_payload", 128'(issue_payload), 128'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_issued = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_ready", 128'(alloc_ready), 128'(1));
    chk("rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("rst_payload", 128'(issue_payload), 128'(0));

    // Single ready instruction, one-cycle latency.
    drv_alloc(5, 1'b1, 0, 1'b0, mkp(1));
    sb_q.push_back(mkp(1));
    tick();
    idle();
    chk("t1_occ1", 128'(occupancy), 128'(1));
    chk("t1_valid", 128'(issue_valid), 128'(1));
    chk("t1_src1", 128'(issue_src1_tag), 128'(5));
    tick();
    chk("t1_occ0", 128'(occupancy), 128'(0));
    chk("t1_idle", 128'(issue_valid), 128'(0));

    // A waits on tag 7, B ready; wake 7 while B is presented.
    drv_alloc(7, 1'b0, 0, 1'b0, mkp(2));
    tick();
    drv_alloc(3, 1'b1, 4, 1'b1, mkp(3));
    tick();
    idle();
`ifdef ISSUE_SCHED_WAKE_BYPASS_EN
    sb_q.push_back(mkp(2));
    sb_q.push_back(mkp(3));
`else
    sb_q.push_back(mkp(3));
    sb_q.push_back(mkp(2));
`endif
    wake_valid = 1'b1;
    wake_tag   = 6'd7;
    tick();
    idle();
    chk("t2_second_valid", 128'(issue_valid), 128'(1));
    tick();
    chk("t2_occ0", 128'(occupancy), 128'(0));

    // Fill all entries on tag 20, drop one, wake all.
    for (int i = 0; i < DEPTH; i++) begin
      drv_alloc(20, 1'b0, 0, 1'b0, mkp(10 + i));
      sb_q.push_back(mkp(10 + i));
      tick();
    end
    idle();
    chk("t3_full_occ", 128'(occupancy), 128'(8));
    chk("t3_full_ready", 128'(alloc_ready), 128'(0));
    drv_alloc(1, 1'b1, 1, 1'b1, mkp(99));
    tick();
    idle();
    chk("t3_drop_occ", 128'(occupancy), 128'(8));
    wake_valid = 1'b1;
    wake_tag   = 6'd20;
    tick();
    idle();
    repeat (9) tick();
    chk("t3_drained", 128'(occupancy), 128'(0));

    // Two ready entries held under stall.
    stall = 1'b1;
    drv_alloc(0, 1'b0, 0, 1'b0, mkp(40));
    tick();
    drv_alloc(0, 1'b0, 0, 1'b0, mkp(41));
    tick();
    alloc_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_hold_valid", 128'(issue_valid), 128'(1));
      chk("t4_hold_pay", 128'(issue_payload), 128'(mkp(40)));
      chk("t4_hold_occ", 128'(occupancy), 128'(2));
      tick();
    end
    stall = 1'b0;
    sb_q.push_back(mkp(40));
    sb_q.push_back(mkp(41));
    tick();
    chk("t4_occ1", 128'(occupancy), 128'(1));
    tick();
    chk("t4_occ0", 128'(occupancy), 128'(0));

    // Flush at occupancy 5 beats alloc and wake.
    for (int i = 0; i < 5; i++) begin
      drv_alloc(30, 1'b0, 0, 1'b0, mkp(50 + i));
      tick();
    end
    idle();
    chk("t5_occ5", 128'(occupancy), 128'(5));
    drv_alloc(1, 1'b1, 1, 1'b1, mkp(60));
    wake_valid = 1'b1;
    wake_tag   = 6'd30;
    flush      = 1'b1;
    #1;
    chk("t5_flush_gate", 128'(issue_valid), 128'(0));
    tick();
    idle();
    chk("t5_occ0", 128'(occupancy), 128'(0));
    chk("t5_no_issue", 128'(issue_valid), 128'(0));
    wake_valid = 1'b1;
    wake_tag   = 6'd30;
    tick();
    idle();
    repeat (3) tick();
    chk("t5_still_empty", 128'(occupancy), 128'(0));

    // Same-cycle wake on an allocating source.
    drv_alloc(2, 1'b1, 40, 1'b0, mkp(70));
    wake_valid = 1'b1;
    wake_tag   = 6'd40;
    sb_q.push_back(mkp(70));
    tick();
    idle();
    chk("t6_valid", 128'(issue_valid), 128'(1));
    chk("t6_src2", 128'(issue_src2_tag), 128'(40));
    tick();
    chk("t6_occ0", 128'(occupancy), 128'(0));

    // Mid-operation reset.
    for (int i = 0; i < 2; i++) begin
      drv_alloc(33, 1'b0, 0, 1'b0, mkp(80 + i));
      tick();
    end
    idle();
    chk("t7_occ2", 128'(occupancy), 128'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_occ0", 128'(occupancy), 128'(0));
    chk("t7_ready", 128'(alloc_ready), 128'(1));
    wake_valid = 1'b1;
    wake_tag   = 6'd33;
    tick();
    idle();
    repeat (2) tick();

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    chk("issued_cnt", 128'(n_issued), 128'(14));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
